// File: rtl/nibble_stream_rx.sv
// Purpose : assembles MSB-first 4-bit nibbles into words and buffers them in a small FIFO.
// Latency : final nibble sampled at edge N -> word_valid visible after edge N (1 cycle).
// Backpressure: word_ready low holds the head word; completed words arriving at a full FIFO are dropped (overflow).
//
// Ports:
//   clk, rst_n              - clock (rising edge), asynchronous active-low reset
//   out_valid, out          - incoming nibble strobe and data
//   clr                     - synchronous clear of overflow, frame_err and word_cnt
//   word_valid, word_data   - FIFO head presentation (valid/ready)
//   word_ready              - consumer accept
//   overflow, frame_err     - sticky error flags
//   word_cnt                - words accepted by the consumer, mod 256
module nibble_stream_rx #(
    parameter int NIBBLES    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_MAX    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   out_valid,
    input  logic [3:0]             out,
    input  logic                   clr,
    output logic                   word_valid,
    output logic [4*NIBBLES-1:0]   word_data,
    input  logic                   word_ready,
    output logic                   overflow,
    output logic                   frame_err,
    output logic [7:0]             word_cnt
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int GAP_W = $clog2(GAP_MAX + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ASM  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       shreg_q, shreg_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [GAP_W-1:0]   gap_q,   gap_d;
    logic [W-1:0]       mem_q [FIFO_DEPTH];
    logic [W-1:0]       mem_d [FIFO_DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic               ovf_q, ovf_d;
    logic               ferr_q, ferr_d;
    logic [7:0]         cnt_q, cnt_d;

    logic               push;
    logic               abort;
    logic [W-1:0]       asm_word;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               push_ok;

    // ------------------------------------------------------------------
    // State register (all flops)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
            cnt_q    <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: assembler
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        push     = 1'b0;
        abort    = 1'b0;
        asm_word = shreg_q;

        if (state_q == S_IDLE) begin
            // First nibble lands in the top slot; lower slots are cleared.
            asm_word          = '0;
            asm_word[W-1 -: 4] = out;
        end else begin
            // Subsequent nibbles fill the slot selected by the index.
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    asm_word[W-1-4*i -: 4] = out;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (out_valid) begin
                    gap_d = '0;
                    if (NIBBLES == 1) begin
                        push = 1'b1;
                    end else begin
                        shreg_d = asm_word;
                        idx_d   = IDX_W'(1);
                        state_d = S_ASM;
                    end
                end
            end
            S_ASM: begin
                if (out_valid) begin
                    // A nibble always wins over a timeout in the same cycle.
                    gap_d = '0;
                    if (idx_q == IDX_W'(NIBBLES - 1)) begin
                        push    = 1'b1;
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        shreg_d = asm_word;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else if (gap_q == GAP_W'(GAP_MAX - 1)) begin
                    abort   = 1'b1;
                    idx_d   = '0;
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                gap_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state: FIFO, flags, counter
    // ------------------------------------------------------------------
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        pop        = !fifo_empty && word_ready;
        // A pop frees the head slot in the same edge, so a full FIFO can still accept.
        push_ok    = push && (!fifo_full || pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = asm_word;
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end

        // clr clears, but an error event in the same cycle still sets its flag.
        ovf_d  = clr ? 1'b0 : ovf_q;
        ferr_d = clr ? 1'b0 : ferr_q;
        if (push && !push_ok) ovf_d  = 1'b1;
        if (abort)            ferr_d = 1'b1;

        if (clr)      cnt_d = '0;
        else if (pop) cnt_d = cnt_q + 8'd1;
        else          cnt_d = cnt_q;
    end

    // ------------------------------------------------------------------
    // Outputs: registered state only, no path from out/out_valid.
    // ------------------------------------------------------------------
    always_comb begin
        word_valid = !fifo_empty;
        word_data  = fifo_empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
        overflow   = ovf_q;
        frame_err  = ferr_q;
        word_cnt   = cnt_q;
    end

endmodule
